packet_dispatcher: RTL and testbench
====================================

PACKET_DISPATCHER -- requirements
Module: packet_dispatcher

Interface
REQ-001 Parameter NUM_PERIPHS, default 8, number of peripheral ports; the SHALL 3-bit address field selects one of them.
REQ-002 Parameter STALL_TIMEOUT, default 1024, SHALL set the blocked cycles before a packet is dropped; 0 SHALL disable dropping.
REQ-003 Parameter DROP_CNT_WIDTH, default 16, SHALL set the width of drop_count.
REQ-004 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 enable  input  1  SHALL gate the start of new FIFO reads; a packet already in flight completes regardless.
REQ-007 fifo_dout  input  32  SHALL carry the USB-to-fabric FIFO read data, valid the cycle after fifo_rd_en (standard, non-FWFT read).
REQ-008 fifo_empty  input  1  SHALL be the FIFO empty flag.
REQ-009 fifo_rd_en  output  1  SHALL be the FIFO read strobe.
REQ-010 periph_tx_data  output  32  SHALL carry the packet broadcast to all peripherals.
REQ-011 periph_tx_valid  output  NUM_PERIPHS  SHALL be a one-hot write strobe, bit = packet address.
REQ-012 periph_tx_full  input  NUM_PERIPHS  SHALL be the per-peripheral TX FIFO full flags.
REQ-013 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-014 drop_count  output  DROP_CNT_WIDTH  SHALL count dropped packets.

Function
REQ-015 Packet address SHALL be fifo_dout[31:29]; addresses >= NUM_PERIPHS SHALL be dropped immediately in HOLD (counted, no valid pulse).
REQ-016 States SHALL be IDLE, FETCH, HOLD.
REQ-017 IDLE: fifo_rd_en = enable & ~fifo_empty; if asserted, next state FETCH.
REQ-018 FETCH: the packet SHALL be captured from fifo_dout into a 32-bit holding register, the stall counter cleared, and the next state SHALL be HOLD; fifo_rd_en low.
REQ-019 HOLD: periph_tx_data SHALL equal the holding register.
REQ-020 HOLD, periph_tx_full[addr]=0: periph_tx_valid[addr] SHALL pulse high for exactly this one cycle.
REQ-021 On leaving HOLD (dispatch or drop), fifo_rd_en SHALL be asserted in the same cycle if enable & ~fifo_empty (next state FETCH), else the next state SHALL be IDLE; sustained throughput SHALL be one packet per 2 cycles.
REQ-022 HOLD, periph_tx_full[addr]=1: no valid, stall counter +1 per cycle, state held.
REQ-023 When the stall counter equals STALL_TIMEOUT-1 while blocked (STALL_TIMEOUT!=0), the packet SHALL be dropped that cycle: no valid pulse, drop_count +1, exit per REQ-021.
REQ-024 Full deasserting in the same cycle as the timeout SHALL dispatch, not drop (full is sampled first).
REQ-025 drop_count SHALL saturate at all-ones and never wrap.
REQ-026 periph_tx_valid SHALL be zero outside HOLD; at most one bit SHALL ever be high.
REQ-027 fifo_rd_en SHALL never be asserted while fifo_empty=1.
REQ-028 enable deasserted mid-packet SHALL not abort FETCH/HOLD; it SHALL only block the next read.
REQ-029 Packet order SHALL be preserved: no FIFO read while a packet is held undispatched.

Reset
REQ-030 On rst: state IDLE; fifo_rd_en=0, periph_tx_valid=0, busy=0, drop_count=0, periph_tx_data=0, stall counter=0.
REQ-031 rst asserted during FETCH or HOLD SHALL discard the held packet with no valid pulse and no drop count.
REQ-032 During rst and the first post-reset cycle, fifo_rd_en SHALL be 0.

Verification
REQ-033 FIFO holds 0x2000_00AA, all not full -> rd_en cycle N, periph_tx_valid=8'h02 with data 0x2000_00AA at N+2, busy high N+1..N+2.
REQ-034 Four back-to-back packets to addr 0..3 -> valid pulses at N+2,N+4,N+6,N+8 in order, rd_en every 2 cycles.
REQ-035 Packet to addr 5, periph_tx_full[5]=1 for 10 cycles then 0 -> one valid pulse 8'h20 on first not-full cycle, drop_count stays 0.
REQ-036 STALL_TIMEOUT=4, full[7] stuck high -> no valid, drop_count=1 after 4 HOLD cycles, next packet fetched same cycle.
REQ-037 DROP_CNT_WIDTH=2, 5 timeouts -> drop_count sequence 1,2,3,3,3.
REQ-038 rst pulsed in HOLD while blocked -> no valid, drop_count=0, IDLE; enable=0 with non-empty FIFO -> rd_en never asserted.

Source files
------------

// File: rtl/packet_dispatcher.sv
// Routes 32-bit packets from a standard-read FIFO to one of NUM_PERIPHS TX ports,
// using the 3-bit address in bits [31:29]. Packets that stay blocked too long are dropped.
module packet_dispatcher #(
    parameter int unsigned NUM_PERIPHS    = 8,
    parameter int unsigned STALL_TIMEOUT  = 1024,
    parameter int unsigned DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [31:0]               fifo_dout,
    input  logic                      fifo_empty,
    output logic                      fifo_rd_en,
    output logic [31:0]               periph_tx_data,
    output logic [NUM_PERIPHS-1:0]    periph_tx_valid,
    input  logic [NUM_PERIPHS-1:0]    periph_tx_full,
    output logic                      busy,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned STALL_W    = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;
    localparam int unsigned TIMEOUT_M1 = (STALL_TIMEOUT == 0) ? 0 : STALL_TIMEOUT - 1;
    localparam logic        TIMEOUT_EN = (STALL_TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   hold_q;
    logic [STALL_W-1:0]  stall_cnt;
    logic                rst_q;

    logic [ADDR_W-1:0]   addr;
    logic                addr_ok;
    logic                rd_ok;
    logic                full_sel;
    logic                capture;
    logic                dispatch;
    logic                drop;
    logic                stall_inc;

    assign addr    = hold_q[DATA_W-1 -: ADDR_W];
    assign addr_ok = 32'(addr) < NUM_PERIPHS;
    // rst_q keeps the read strobe low for the first cycle after reset
    assign rd_ok   = enable & ~fifo_empty & ~rst_q;

    assign periph_tx_data = hold_q;
    assign busy           = (state != IDLE) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        fifo_rd_en      = 1'b0;
        periph_tx_valid = '0;
        capture         = 1'b0;
        dispatch        = 1'b0;
        drop            = 1'b0;
        stall_inc       = 1'b0;
        full_sel        = 1'b0;

        for (int i = 0; i < NUM_PERIPHS; i++) begin
            if (addr == ADDR_W'(i)) full_sel = periph_tx_full[i];
        end

        if (!rst) begin
            case (state)
                IDLE: begin
                    if (rd_ok) begin
                        fifo_rd_en = 1'b1;
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
                HOLD: begin
                    // full is checked before the timeout so a late release still dispatches
                    if (!addr_ok) begin
                        drop = 1'b1;
                    end else if (!full_sel) begin
                        dispatch = 1'b1;
                    end else if (TIMEOUT_EN && (stall_cnt == STALL_W'(TIMEOUT_M1))) begin
                        drop = 1'b1;
                    end else begin
                        stall_inc = 1'b1;
                    end

                    if (dispatch || drop) begin
                        if (rd_ok) begin
                            fifo_rd_en = 1'b1;
                            state_next = FETCH;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        for (int i = 0; i < NUM_PERIPHS; i++) begin
            periph_tx_valid[i] = dispatch && (addr == ADDR_W'(i));
        end
    end

    // Holding register, stall counter and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q      <= 1'b1;
            hold_q     <= '0;
            stall_cnt  <= '0;
            drop_count <= '0;
        end else begin
            rst_q <= 1'b0;
            if (capture) begin
                hold_q    <= fifo_dout;
                stall_cnt <= '0;
            end else if (stall_inc) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + DROP_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_packet_dispatcher.sv
// Directed bench: dut_a (6 ports, long timeout) covers dispatch, streaming, stall and
// out-of-range drop; dut_b (timeout 4, 2-bit counter) covers timeouts, saturation and reset.
module tb_packet_dispatcher;

    logic        clk;
    logic        rst;

    logic        enable_a, empty_a, rd_en_a, busy_a;
    logic [31:0] dout_a, data_a;
    logic [5:0]  valid_a, full_a;
    logic [15:0] drop_a;

    logic        enable_b, empty_b, rd_en_b, busy_b;
    logic [31:0] dout_b, data_b;
    logic [7:0]  valid_b, full_b;
    logic [1:0]  drop_b;

    logic        ra_a, ra_b;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    int total = 0;
    int bad   = 0;

    logic [5:0]  exp_v  [0:8];
    logic        exp_rd [0:8];
    logic [31:0] pkts   [0:3];
    logic [1:0]  exp_dc [0:4];

    packet_dispatcher #(
        .NUM_PERIPHS(6), .STALL_TIMEOUT(1024), .DROP_CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable_a),
        .fifo_dout(dout_a), .fifo_empty(empty_a), .fifo_rd_en(rd_en_a),
        .periph_tx_data(data_a), .periph_tx_valid(valid_a), .periph_tx_full(full_a),
        .busy(busy_a), .drop_count(drop_a)
    );

    packet_dispatcher #(
        .NUM_PERIPHS(8), .STALL_TIMEOUT(4), .DROP_CNT_WIDTH(2)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b),
        .fifo_dout(dout_b), .fifo_empty(empty_b), .fifo_rd_en(rd_en_b),
        .periph_tx_data(data_b), .periph_tx_valid(valid_b), .periph_tx_full(full_b),
        .busy(busy_b), .drop_count(drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // read strobes as seen by the FIFO at the active edge
    always @(posedge clk) begin
        ra_a <= rd_en_a;
        ra_b <= rd_en_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // advance to the next falling edge; FIFO data appears the cycle after a read
    task automatic nxt();
        @(negedge clk);
        if (ra_a === 1'b1 && q_a.size() > 0) dout_a = q_a.pop_front();
        if (ra_b === 1'b1 && q_b.size() > 0) dout_b = q_b.pop_front();
        empty_a = (q_a.size() == 0);
        empty_b = (q_b.size() == 0);
        #1;
    endtask

    task automatic push_a(input logic [31:0] d);
        q_a.push_back(d);
        empty_a = 1'b0;
    endtask

    task automatic push_b(input logic [31:0] d);
        q_b.push_back(d);
        empty_b = 1'b0;
    endtask

    initial begin
        exp_v  = '{6'h00, 6'h00, 6'h01, 6'h00, 6'h02, 6'h00, 6'h04, 6'h00, 6'h08};
        exp_rd = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        pkts   = '{32'h0000_0011, 32'h2000_0022, 32'h4000_0033, 32'h6000_0044};
        exp_dc = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst = 1'b1;
        enable_a = 1'b1; empty_a = 1'b1; dout_a = '0; full_a = '0;
        enable_b = 1'b0; empty_b = 1'b1; dout_b = '0; full_b = '0;
        push_a(32'h2000_00AA);
        push_b(32'hE000_0001);

        // reset state
        nxt();
        chk("rst_rd_en", 32'(rd_en_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_valid", 32'(valid_a), 32'h0);
        chk("rst_data", data_a, 32'h0);
        chk("rst_drop", 32'(drop_a), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_rd_en", 32'(rd_en_a), 32'h0);

        // single packet to address 1
        nxt();
        chk("single_rd_en_N", 32'(rd_en_a), 32'h1);
        chk("single_busy_N", 32'(busy_a), 32'h0);
        nxt();
        chk("single_busy_N1", 32'(busy_a), 32'h1);
        chk("single_valid_N1", 32'(valid_a), 32'h0);
        chk("single_rd_en_N1", 32'(rd_en_a), 32'h0);
        nxt();
        chk("single_valid_N2", 32'(valid_a), 32'h02);
        chk("single_data_N2", data_a, 32'h2000_00AA);
        chk("single_busy_N2", 32'(busy_a), 32'h1);
        chk("single_rd_en_N2", 32'(rd_en_a), 32'h0);
        nxt();
        chk("single_busy_N3", 32'(busy_a), 32'h0);
        chk("single_valid_N3", 32'(valid_a), 32'h0);

        // four back-to-back packets, one per two cycles
        for (int i = 0; i < 4; i++) push_a(pkts[i]);
        #1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) nxt();
            chk($sformatf("stream_rd_en_%0d", k), 32'(rd_en_a), 32'(exp_rd[k]));
            chk($sformatf("stream_valid_%0d", k), 32'(valid_a), 32'(exp_v[k]));
            if (k >= 2 && (k % 2) == 0)
                chk($sformatf("stream_data_%0d", k), data_a, pkts[k/2 - 1]);
            chk($sformatf("idle_b_rd_en_%0d", k), 32'(rd_en_b), 32'h0);
        end

        // address 5 blocked for ten cycles, then released
        nxt();
        full_a = 6'h20;
        push_a(32'hA000_0055);
        #1;
        chk("stall_rd_en", 32'(rd_en_a), 32'h1);
        nxt();
        for (int k = 0; k < 10; k++) begin
            nxt();
            chk($sformatf("stall_valid_%0d", k), 32'(valid_a), 32'h0);
        end
        chk("stall_busy", 32'(busy_a), 32'h1);
        nxt();
        full_a = 6'h00;
        #1;
        chk("release_valid", 32'(valid_a), 32'h20);
        chk("release_data", data_a, 32'hA000_0055);
        nxt();
        chk("release_drop", 32'(drop_a), 32'h0);
        chk("release_busy", 32'(busy_a), 32'h0);

        // address 6 is outside the 6-port range: dropped at once
        push_a(32'hC000_0077);
        #1;
        chk("oor_rd_en", 32'(rd_en_a), 32'h1);
        nxt();
        nxt();
        chk("oor_valid", 32'(valid_a), 32'h0);
        chk("oor_busy", 32'(busy_a), 32'h1);
        nxt();
        chk("oor_drop", 32'(drop_a), 32'h1);
        chk("oor_idle", 32'(busy_a), 32'h0);

        // disabled dut_b never read its non-empty FIFO
        chk("disabled_b_busy", 32'(busy_b), 32'h0);
        chk("disabled_b_qsize", 32'(q_b.size()), 32'h1);

        // timeout 4 with address 7 stuck full; next packet fetched on the drop cycle
        full_b = 8'h80;
        push_b(32'h0000_0002);
        enable_b = 1'b1;
        #1;
        chk("to_rd_en_N", 32'(rd_en_b), 32'h1);
        nxt();
        for (int k = 1; k <= 4; k++) begin
            nxt();
            chk($sformatf("to_valid_hold%0d", k), 32'(valid_b), 32'h0);
            chk($sformatf("to_drop_hold%0d", k), 32'(drop_b), 32'h0);
            chk($sformatf("to_rd_en_hold%0d", k), 32'(rd_en_b), (k == 4) ? 32'h1 : 32'h0);
        end
        nxt();
        chk("to_drop_after", 32'(drop_b), 32'h1);
        chk("to_refetch_busy", 32'(busy_b), 32'h1);
        nxt();
        chk("to_next_valid", 32'(valid_b), 32'h01);
        chk("to_next_data", data_b, 32'h0000_0002);
        nxt();
        chk("to_idle", 32'(busy_b), 32'h0);

        // reset while blocked in HOLD discards the packet
        push_b(32'hE000_0003);
        #1;
        chk("rh_rd_en", 32'(rd_en_b), 32'h1);
        nxt();
        nxt();
        chk("rh_busy_hold", 32'(busy_b), 32'h1);
        nxt();
        rst = 1'b1;
        #1;
        chk("rh_valid_in_rst", 32'(valid_b), 32'h0);
        chk("rh_rd_en_in_rst", 32'(rd_en_b), 32'h0);
        nxt();
        chk("rh_busy_after", 32'(busy_b), 32'h0);
        chk("rh_drop_after", 32'(drop_b), 32'h0);
        chk("rh_data_after", data_b, 32'h0);
        rst = 1'b0;
        #1;
        chk("rh_rd_en_post", 32'(rd_en_b), 32'h0);

        // five timeouts saturate the 2-bit drop counter
        nxt();
        for (int i = 0; i < 5; i++) push_b(32'hE000_0100 + 32'(i));
        #1;
        chk("sat_rd_en", 32'(rd_en_b), 32'h1);
        nxt();
        for (int i = 0; i < 5; i++) begin
            repeat (5) nxt();
            chk($sformatf("sat_drop_%0d", i), 32'(drop_b), 32'(exp_dc[i]));
            chk($sformatf("sat_valid_%0d", i), 32'(valid_b), 32'h0);
        end
        chk("sat_idle", 32'(busy_b), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
